// File: rtl/data_memory_system.sv
// rtl/data_memory_system.sv - direct-mapped write-back write-allocate cache over internal main memory (DATA_MEMORY_STATS_EN adds hit/miss counters)
module data_memory_system #(
    parameter int data_length    = 32,
    parameter int address_length = 10,
    parameter int MEM_LATENCY    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [address_length-1:0] address,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [data_length-1:0]    DataIn,
    output logic [data_length-1:0]    DataOut,
    output logic                      stall
`ifdef DATA_MEMORY_STATS_EN
    ,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
`endif
);

    localparam int         TAG_W     = address_length - 7;
    localparam int         LINES     = 32;
    localparam int         WORDS     = 4;
    localparam int         MEM_WORDS = 2 ** address_length;
    localparam logic [3:0] LAST_CNT  = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t                 state;
    logic [3:0]             lat_cnt;
    logic [LINES-1:0]       valid;
    logic [LINES-1:0]       dirty;
    logic [TAG_W-1:0]       tag_ram  [LINES];
    logic [data_length-1:0] data_ram [LINES][WORDS];

    // Main memory starts zeroed and is deliberately untouched by reset.
    logic [data_length-1:0] main_mem [MEM_WORDS] = '{default: '0};

    logic [1:0]       req_off;
    logic [4:0]       req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             request;
    logic             hit;
    logic             victim_dirty;
    logic             xfer_done;
    logic             write_hit;
    logic             alloc_fill;
    logic             wb_flush;

    assign req_off      = address[1:0];
    assign req_idx      = address[6:2];
    assign req_tag      = address[address_length-1:7];
    assign request      = MemRead | MemWrite;
    assign hit          = valid[req_idx] && (tag_ram[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];
    assign xfer_done    = (lat_cnt == LAST_CNT);

    // MemWrite wins when both request lines are high.
    assign write_hit  = (state == COMPARE) && MemWrite && hit;
    assign alloc_fill = (state == ALLOCATE) && xfer_done;
    assign wb_flush   = (state == WRITEBACK) && xfer_done;

    // Stall is combinational so a miss is flagged in the very cycle it is seen; forced low while in reset.
    assign stall = reset && ((state != COMPARE) || (request && !hit));

    // Controller: lookup, victim write-back, line allocation, plus line status bits and read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= COMPARE;
            lat_cnt <= 4'd0;
            valid   <= '0;
            dirty   <= '0;
            DataOut <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (request) begin
                        if (hit) begin
                            if (MemWrite) begin
                                dirty[req_idx] <= 1'b1;
                            end else begin
                                DataOut <= data_ram[req_idx][req_off];
                            end
                        end else begin
                            lat_cnt <= 4'd0;
                            state   <= victim_dirty ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (xfer_done) begin
                        lat_cnt <= 4'd0;
                        state   <= ALLOCATE;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                ALLOCATE: begin
                    if (xfer_done) begin
                        lat_cnt        <= 4'd0;
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        state          <= COMPARE;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                default: begin
                    lat_cnt <= 4'd0;
                    state   <= COMPARE;
                end
            endcase
        end
    end

    // Cache data and tag arrays: filled on the last allocate cycle, patched by write hits.
    always_ff @(posedge clock) begin
        if (alloc_fill) begin
            tag_ram[req_idx] <= req_tag;
            for (int w = 0; w < WORDS; w++) begin
                data_ram[req_idx][w] <= main_mem[{req_tag, req_idx, 2'(w)}];
            end
        end else if (write_hit) begin
            data_ram[req_idx][req_off] <= DataIn;
        end
    end

    // Main memory: the whole victim block lands on the final write-back cycle.
    always_ff @(posedge clock) begin
        if (wb_flush) begin
            for (int w = 0; w < WORDS; w++) begin
                main_mem[{tag_ram[req_idx], req_idx, 2'(w)}] <= data_ram[req_idx][w];
            end
        end
    end

`ifdef DATA_MEMORY_STATS_EN
    // Saturating hit/miss counters sampled on COMPARE-state requests.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= 16'd0;
            miss_count <= 16'd0;
        end else if ((state == COMPARE) && request) begin
            if (hit) begin
                if (hit_count != 16'hFFFF) begin
                    hit_count <= hit_count + 16'd1;
                end
            end else begin
                if (miss_count != 16'hFFFF) begin
                    miss_count <= miss_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_system.sv
// tb/tb_data_memory_system.sv - directed self-checking bench for data_memory_system
module tb_data_memory_system;

    localparam int LAT = 4;

    logic        clock;
    logic        reset;
    logic [9:0]  address;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        stall;

    int checks;
    int failures;
    int n_stall;

    data_memory_system #(
        .data_length   (32),
        .address_length(10),
        .MEM_LATENCY   (LAT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .MemRead (MemRead),
        .MemWrite(MemWrite),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .stall   (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request: present at negedge, count stalled cycles, complete on the first unstalled edge.
    task automatic access(input logic [9:0] a, input logic rd, input logic wr,
                          input logic [31:0] d, output int stalls);
        @(negedge clock);
        address  = a;
        MemRead  = rd;
        MemWrite = wr;
        DataIn   = d;
        stalls   = 0;
        #1;
        while (stall && stalls < 100) begin
            stalls++;
            @(posedge clock);
            #1;
        end
        if (stalls >= 100) begin
            check("stall_timeout", 32'(stalls), 32'd0);
        end
        @(posedge clock);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        address  = 10'h000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        DataIn   = 32'h0;

        #1;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_dataout", DataOut, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Idle with a changing address must never stall.
        address = 10'h155;
        #1;
        check("idle_no_stall", {31'd0, stall}, 32'd0);

        // Cold write miss on a clean line: allocate only.
        access(10'h020, 1'b0, 1'b1, 32'hAAAAAAAA, n_stall);
        check("wr020_stalls", 32'(n_stall), 32'(LAT + 1));
        check("wr020_dirty", {31'd0, dut.dirty[8]}, 32'd1);
        check("wr020_dataout_held", DataOut, 32'h0);

        // Read hits, no stall.
        access(10'h020, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd020_stalls", 32'(n_stall), 32'd0);
        check("rd020_data", DataOut, 32'hAAAAAAAA);
        access(10'h020, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd020_again_stalls", 32'(n_stall), 32'd0);
        check("rd020_again_data", DataOut, 32'hAAAAAAAA);

        // Conflict miss on dirty line: write-back then allocate.
        access(10'h120, 1'b0, 1'b1, 32'hBBBBBBBB, n_stall);
        check("wr120_stalls", 32'(n_stall), 32'(2 * LAT + 1));
        check("mem020_written_back", dut.main_mem[10'h020], 32'hAAAAAAAA);
        check("mem021_written_back", dut.main_mem[10'h021], 32'h0);

        access(10'h220, 1'b0, 1'b1, 32'hCCCCCCCC, n_stall);
        check("wr220_stalls", 32'(n_stall), 32'(2 * LAT + 1));
        check("mem120_written_back", dut.main_mem[10'h120], 32'hBBBBBBBB);

        access(10'h120, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd120_stalls", 32'(n_stall), 32'(2 * LAT + 1));
        check("rd120_data", DataOut, 32'hBBBBBBBB);
        check("mem220_written_back", dut.main_mem[10'h220], 32'hCCCCCCCC);

        // Unwritten location reads as zero after a clean miss.
        access(10'h3FF, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd3ff_stalls", 32'(n_stall), 32'(LAT + 1));
        check("rd3ff_data", DataOut, 32'h0);

        // Reset in the middle of an allocate.
        access(10'h120, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd120_hit_stalls", 32'(n_stall), 32'd0);
        check("rd120_hit_data", DataOut, 32'hBBBBBBBB);
        @(negedge clock);
        address = 10'h020;
        MemRead = 1'b1;
        #1;
        check("rd020_miss_stall", {31'd0, stall}, 32'd1);
        @(posedge clock);
        @(posedge clock);
        #2;
        check("mid_alloc_stall", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        #1;
        check("reset_mid_alloc_stall", {31'd0, stall}, 32'd0);
        check("reset_mid_alloc_dataout", DataOut, 32'h0);
        @(negedge clock);
        MemRead = 1'b0;
        reset   = 1'b1;

        access(10'h020, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd020_after_reset_stalls", 32'(n_stall), 32'(LAT + 1));
        check("rd020_after_reset_data", DataOut, 32'hAAAAAAAA);

        // Both request lines high: treated as a write, DataOut held.
        access(10'h021, 1'b1, 1'b1, 32'h12345678, n_stall);
        check("both_stalls", 32'(n_stall), 32'd0);
        check("both_dataout_held", DataOut, 32'hAAAAAAAA);
        check("both_dirty", {31'd0, dut.dirty[8]}, 32'd1);
        access(10'h021, 1'b1, 1'b0, 32'h0, n_stall);
        check("rd021_stalls", 32'(n_stall), 32'd0);
        check("rd021_data", DataOut, 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
